// File: rtl/rv32_inst_encoder.sv
// RV32I descriptor -> machine-word encoder streaming words to sequential instruction-memory addresses.
// Optional NOP fill of the remaining image is enabled by defining INST_ENC_NOP_PAD_EN (adds the pad input).
module rv32_inst_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
`ifdef INST_ENC_NOP_PAD_EN
  input  logic              pad,
`endif
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code
);

  // state  | meaning
  // S_IDLE | out of reset, waiting for start
  // S_RUN  | accepting descriptors, one output word in flight at most
  // S_FULL | every address of the image written
  // S_PAD  | writing NOPs to the remaining addresses (pad build only)
`ifdef INST_ENC_NOP_PAD_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FULL, S_PAD} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FULL} state_t;
`endif

  localparam logic [31:0]       NOP      = 32'h0000_0013;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t             state, state_nxt;
  logic               wr_hs, last_hs, accept;
  logic               bad_op, bad_imm;
  logic [31:0]        enc;
  logic [2:0]         f3;
  logic [6:0]         f7;
  logic signed [31:0] simm;
  logic [1:0]         err_set;
  logic               load;
  logic [31:0]        load_data;

  assign simm    = in_imm;
  assign wr_hs   = wr_valid & wr_ready;
  assign last_hs = wr_hs & (wr_addr == '1);
  assign accept  = in_valid & in_ready;

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        in_ready = !wr_valid || wr_ready;
        if (start)        state_nxt = S_RUN;
        else if (last_hs) state_nxt = S_FULL;
`ifdef INST_ENC_NOP_PAD_EN
        else if (pad)     state_nxt = S_PAD;
`endif
      end
      S_FULL: if (start) state_nxt = S_RUN;
`ifdef INST_ENC_NOP_PAD_EN
      S_PAD: begin
        if (start)        state_nxt = S_RUN;
        else if (last_hs) state_nxt = S_FULL;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    enc     = 32'h0;
    bad_op  = 1'b0;
    bad_imm = 1'b0;
    f3      = 3'b000;
    f7      = 7'b0000000;
    case (in_op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7: begin
        case (in_op[2:0])
          3'd2:       f3 = 3'b111;
          3'd3:       f3 = 3'b110;
          3'd4:       f3 = 3'b100;
          3'd5:       f3 = 3'b001;
          3'd6, 3'd7: f3 = 3'b101;
          default:    f3 = 3'b000;
        endcase
        if (in_op == 5'd1 || in_op == 5'd7) f7 = 7'b0100000;
        enc = {f7, in_rs2, in_rs1, f3, in_rd, 7'b0110011};
      end
      5'd8, 5'd9, 5'd10, 5'd11, 5'd15, 5'd16: begin
        case (in_op)
          5'd9:    f3 = 3'b111;
          5'd10:   f3 = 3'b110;
          5'd11:   f3 = 3'b100;
          5'd15:   f3 = 3'b010;
          default: f3 = 3'b000;
        endcase
        bad_imm = (simm < -32'sd2048) || (simm > 32'sd2047);
        enc = {in_imm[11:0], in_rs1, f3, in_rd,
               (in_op == 5'd15) ? 7'b0000011 : (in_op == 5'd16) ? 7'b1100111 : 7'b0010011};
      end
      5'd12, 5'd13, 5'd14: begin
        f3 = (in_op == 5'd12) ? 3'b001 : 3'b101;
        if (in_op == 5'd14) f7 = 7'b0100000;
        bad_imm = (simm < 32'sd0) || (simm > 32'sd31);
        enc = {f7, in_imm[4:0], in_rs1, f3, in_rd, 7'b0010011};
      end
      5'd17: begin
        bad_imm = (simm < -32'sd2048) || (simm > 32'sd2047);
        enc = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
      end
      5'd18: begin
        bad_imm = (in_imm[11:0] != 12'h000);
        enc = {in_imm[31:12], in_rd, 7'b0110111};
      end
      5'd19, 5'd20, 5'd21, 5'd22: begin
        case (in_op)
          5'd20:   f3 = 3'b001;
          5'd21:   f3 = 3'b100;
          5'd22:   f3 = 3'b101;
          default: f3 = 3'b000;
        endcase
        bad_imm = (simm < -32'sd4096) || (simm > 32'sd4094) || in_imm[0];
        enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3, in_imm[4:1], in_imm[11], 7'b1100011};
      end
      5'd23: begin
        bad_imm = (simm < -32'sd1048576) || (simm > 32'sd1048574) || in_imm[0];
        enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
      end
      default: bad_op = 1'b1;
    endcase
  end

  // A descriptor accepted while the final word leaves has nowhere to go: treated as a write while full.
  always_comb begin
    err_set   = 2'd0;
    load      = 1'b0;
    load_data = enc;
    if (state == S_RUN && accept) begin
      if (last_hs)      err_set = 2'd3;
      else if (bad_op)  err_set = 2'd1;
      else if (bad_imm) err_set = 2'd2;
      else              load    = 1'b1;
    end else if (state == S_FULL && in_valid) begin
      err_set = 2'd3;
    end
`ifdef INST_ENC_NOP_PAD_EN
    if (state == S_PAD && (!wr_valid || wr_ready) && !last_hs) begin
      load      = 1'b1;
      load_data = NOP;
    end
`endif
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= 32'h0;
      full     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'd0;
    end else if (start) begin
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      full     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'd0;
    end else begin
      if (wr_hs) begin
        wr_addr  <= wr_addr + ADDR_ONE;
        wr_valid <= 1'b0;
      end
      if (last_hs) full <= 1'b1;
      if (load) begin
        wr_valid <= 1'b1;
        wr_data  <= load_data;
      end
      if (err_set != 2'd0) begin
        err <= 1'b1;
        if (err_code == 2'd0) err_code <= err_set;
      end
    end
  end

endmodule

// File: tb/tb_rv32_inst_encoder.sv
// Bench for rv32_inst_encoder (4-word image): directed encodings, error, backpressure and full cases,
// plus randomized descriptors scored against an arithmetic RV32I encoding model.
module tb_rv32_inst_encoder;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int R_F3[8] = '{0, 0, 7, 6, 4, 1, 5, 5};
  localparam int I_F3[4] = '{0, 7, 6, 4};
  localparam int B_F3[4] = '{0, 1, 4, 5};

  logic          cpu_clk = 1'b0;
  logic          cpu_rst_n, start, in_valid, in_ready, wr_valid, wr_ready;
  logic [4:0]    in_op, in_rd, in_rs1, in_rs2;
  logic [31:0]   in_imm, wr_data;
  logic [AW-1:0] wr_addr;
  logic          busy, full, err;
  logic [1:0]    err_code;
`ifdef INST_ENC_NOP_PAD_EN
  logic          pad;
`endif

  int vectors = 0, miscompares = 0;
  logic [AW+31:0] got_q[$], exp_q[$];
  int m_addr, m_code;
  bit last_acc;

  rv32_inst_encoder #(.ADDR_W(AW)) dut (
    .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
`ifdef INST_ENC_NOP_PAD_EN
    .pad(pad),
`endif
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .full(full), .err(err), .err_code(err_code)
  );

  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference encoding built from the instruction-format field positions with integer arithmetic.
  function automatic void ref_encode(input int op, input int rd, input int rs1, input int rs2,
                                     input int imm, output logic [31:0] w, output int code);
    int v;
    v = 0;
    code = 0;
    if (op <= 7) begin
      v = (((op == 1 || op == 7) ? 32 : 0) << 25) | (rs2 << 20) | (rs1 << 15) | (R_F3[op] << 12) | (rd << 7) | 'h33;
    end else if (op <= 11 || op == 15 || op == 16) begin
      if (imm < -2048 || imm > 2047) code = 2;
      if (op == 15)      v = (2 << 12) | 'h03;
      else if (op == 16) v = 'h67;
      else               v = (I_F3[op-8] << 12) | 'h13;
      v = v | ((imm & 'hFFF) << 20) | (rs1 << 15) | (rd << 7);
    end else if (op <= 14) begin
      if (imm < 0 || imm > 31) code = 2;
      v = (((op == 14) ? 32 : 0) << 25) | ((imm & 31) << 20) | (rs1 << 15) |
          (((op == 12) ? 1 : 5) << 12) | (rd << 7) | 'h13;
    end else if (op == 17) begin
      if (imm < -2048 || imm > 2047) code = 2;
      v = (((imm >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12) | ((imm & 31) << 7) | 'h23;
    end else if (op == 18) begin
      if ((imm % 4096) != 0) code = 2;
      v = (imm & ~4095) | (rd << 7) | 'h37;
    end else if (op <= 22) begin
      if (imm < -4096 || imm > 4094 || (imm % 2) != 0) code = 2;
      v = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3F) << 25) | (rs2 << 20) | (rs1 << 15) |
          (B_F3[op-19] << 12) | (((imm >> 1) & 'hF) << 8) | (((imm >> 11) & 1) << 7) | 'h63;
    end else if (op == 23) begin
      if (imm < -1048576 || imm > 1048574 || (imm % 2) != 0) code = 2;
      v = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 'h3FF) << 21) | (((imm >> 11) & 1) << 20) |
          (((imm >> 12) & 'hFF) << 12) | (rd << 7) | 'h6F;
    end else begin
      code = 1;
    end
    w = v;
  endfunction

  function automatic int rand_imm(input int op);
    int v;
    case ($urandom_range(0, 4))
      0:       v = int'($urandom_range(0, 31));
      1:       v = int'($urandom_range(0, 4095)) - 2048;
      2:       v = int'($urandom_range(0, 8191)) - 4096;
      3:       v = int'($urandom_range(0, 2097151)) - 1048576;
      default: v = int'($urandom);
    endcase
    if (op == 18 && $urandom_range(0, 1) == 1) v = v & ~4095;
    if ($urandom_range(0, 1) == 1) v = v & ~1;
    return v;
  endfunction

  // One clock: sample handshakes mid-cycle, update the scoreboard, land 1 time unit after the edge.
  task automatic tick();
    logic [31:0] w;
    int code;
    #1;
    last_acc = 1'b0;
    if (!start) begin
      if (wr_valid && wr_ready) got_q.push_back({wr_addr, wr_data});
      if (in_valid && in_ready) begin
        last_acc = 1'b1;
        ref_encode(int'(in_op), int'(in_rd), int'(in_rs1), int'(in_rs2), int'(in_imm), w, code);
        if (code == 0) begin
          exp_q.push_back({m_addr[AW-1:0], w});
          m_addr++;
        end else if (m_code == 0) begin
          m_code = code;
        end
      end
    end
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic set_desc(input int op, input int rd, input int rs1, input int rs2, input int imm);
    in_op  = op[4:0];
    in_rd  = rd[4:0];
    in_rs1 = rs1[4:0];
    in_rs2 = rs2[4:0];
    in_imm = imm;
  endtask

  task automatic send(input int op, input int rd, input int rs1, input int rs2, input int imm);
    set_desc(op, rd, rs1, rs2, imm);
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (last_acc) break;
    end
    in_valid = 1'b0;
    vectors++;
    if (!last_acc) begin
      miscompares++;
      $display("FAIL send_timeout: op %0d not accepted within 50 cycles, required acceptance", op);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    in_valid = 1'b0;
    tick();
    start = 1'b0;
    got_q.delete();
    exp_q.delete();
    m_addr = 0;
    m_code = 0;
  endtask

  task automatic test_reset();
    cpu_rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; wr_ready = 1'b0;
    set_desc(0, 0, 0, 0, 0);
`ifdef INST_ENC_NOP_PAD_EN
    pad = 1'b0;
`endif
    repeat (3) tick();
    vectors++;
    if ({wr_valid, wr_addr, wr_data, full, err, err_code, in_ready, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b a=%h d=%h f=%b e=%b c=%0d r=%b b=%b, required all zero",
               wr_valid, wr_addr, wr_data, full, err, err_code, in_ready, busy);
    end
    cpu_rst_n = 1'b1;
    in_valid = 1'b1;
    tick();
    vectors++;
    if ({in_ready, busy, wr_valid, err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL idle_state: got ready=%b busy=%b wr_valid=%b err=%b, required 0000", in_ready, busy, wr_valid, err);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_encode();
    do_start();
    wr_ready = 1'b1;
    vectors++;
    if ({busy, in_ready} !== 2'b11) begin
      miscompares++;
      $display("FAIL run_entry: got busy=%b ready=%b, required 11", busy, in_ready);
    end
    send(8, 1, 0, 0, 5);
    vectors++;
    if ({wr_valid, wr_addr, wr_data} !== {1'b1, 2'd0, 32'h00500093}) begin
      miscompares++;
      $display("FAIL addi_word: got v=%b a=%0d d=%h, required v=1 a=0 d=00500093", wr_valid, wr_addr, wr_data);
    end
    tick();
    do_start();
    send(0, 3, 1, 2, 0);
    vectors++;
    if ({wr_addr, wr_data} !== {2'd0, 32'h002081B3}) begin
      miscompares++;
      $display("FAIL add_word: got a=%0d d=%h, required a=0 d=002081b3", wr_addr, wr_data);
    end
    send(17, 0, 1, 2, 8);
    vectors++;
    if ({wr_valid, wr_addr, wr_data} !== {1'b1, 2'd1, 32'h0020A423}) begin
      miscompares++;
      $display("FAIL sw_word: got v=%b a=%0d d=%h, required v=1 a=1 d=0020a423", wr_valid, wr_addr, wr_data);
    end
    tick();
    do_start();
    send(14, 5, 6, 0, 31);
    vectors++;
    if (wr_data !== 32'h41F35293 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL srai_31: got d=%h err=%b, required d=41f35293 err=0", wr_data, err);
    end
    tick();
    send(13, 5, 6, 0, 32);
    vectors++;
    if ({err, err_code, wr_valid} !== {1'b1, 2'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL srli_32: got err=%b code=%0d v=%b, required err=1 code=2 v=0", err, err_code, wr_valid);
    end
  endtask

  task automatic test_errors();
    do_start();
    wr_ready = 1'b1;
    send(19, 0, 1, 2, -3);
    vectors++;
    if ({err, err_code, wr_valid} !== {1'b1, 2'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL beq_odd: got err=%b code=%0d v=%b, required err=1 code=2 v=0", err, err_code, wr_valid);
    end
    send(19, 0, 1, 2, -4);
    vectors++;
    if ({wr_valid, wr_addr, wr_data} !== {1'b1, 2'd0, 32'hFE208EE3}) begin
      miscompares++;
      $display("FAIL beq_after_err: got v=%b a=%0d d=%h, required v=1 a=0 d=fe208ee3", wr_valid, wr_addr, wr_data);
    end
    tick();
    send(26, 1, 1, 1, 0);
    vectors++;
    if ({err, err_code, wr_addr, wr_valid} !== {1'b1, 2'd2, 2'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL sticky_code: got err=%b code=%0d a=%0d v=%b, required err=1 code=2 a=1 v=0",
               err, err_code, wr_addr, wr_valid);
    end
    do_start();
    send(30, 1, 1, 1, 0);
    vectors++;
    if (err_code !== 2'd1) begin
      miscompares++;
      $display("FAIL bad_op: got code=%0d, required 1", err_code);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    do_start();
    wr_ready = 1'b0;
    send(10, 7, 8, 0, -1);
    held = wr_data;
    set_desc(11, 9, 10, 0, 100);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if ({in_ready, wr_valid, wr_addr, wr_data} !== {1'b0, 1'b1, 2'd0, held}) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got r=%b v=%b a=%0d d=%h, required r=0 v=1 a=0 d=%h",
                 i, in_ready, wr_valid, wr_addr, wr_data, held);
      end
    end
    wr_ready = 1'b1;
    for (int i = 0; i < 10 && !last_acc; i++) tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && got_q.size() < 2; i++) tick();
    vectors++;
    if (got_q.size() != 2 || exp_q.size() != 2) begin
      miscompares++;
      $display("FAIL stall_count: got %0d words (model %0d), required 2", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (got_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL stall_word[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_full();
    do_start();
    wr_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) send(8, i + 1, 0, 0, i);
    tick();
    tick();
    vectors++;
    if ({full, busy, wr_valid, got_q.size() == DEPTH} !== 4'b1101) begin
      miscompares++;
      $display("FAIL full_flag: got full=%b busy=%b v=%b words=%0d, required 1,1,0,%0d",
               full, busy, wr_valid, got_q.size(), DEPTH);
    end
    set_desc(0, 1, 2, 3, 0);
    in_valid = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full_ready: got in_ready=%b, required 0", in_ready);
    end
    tick();
    in_valid = 1'b0;
    vectors++;
    if ({err, err_code} !== {1'b1, 2'd3}) begin
      miscompares++;
      $display("FAIL full_write: got err=%b code=%0d, required err=1 code=3", err, err_code);
    end
    do_start();
    vectors++;
    if ({wr_addr, full, err, err_code, in_ready} !== {2'd0, 1'b0, 1'b0, 2'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL restart: got a=%0d full=%b err=%b code=%0d r=%b, required 0,0,0,0,1",
               wr_addr, full, err, err_code, in_ready);
    end
  endtask

  task automatic test_random();
    int op, nacc;
    for (int img = 0; img < 15; img++) begin
      do_start();
      nacc = 0;
      for (int c = 0; c < 300 && exp_q.size() < DEPTH && nacc < 10; c++) begin
        if (!in_valid && $urandom_range(0, 9) < 6) begin
          op = int'($urandom_range(0, 27));
          set_desc(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                   int'($urandom_range(0, 31)), rand_imm(op));
          in_valid = 1'b1;
        end
        wr_ready = ($urandom_range(0, 9) < 7);
        tick();
        if (last_acc) begin
          nacc++;
          in_valid = 1'b0;
        end
      end
      in_valid = 1'b0;
      wr_ready = 1'b1;
      for (int c = 0; c < 20 && got_q.size() < exp_q.size(); c++) tick();
      vectors++;
      if (got_q.size() != exp_q.size()) begin
        miscompares++;
        $display("FAIL rand_count[%0d]: got %0d words, required %0d", img, got_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          vectors++;
          if (got_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL rand_word[%0d.%0d]: got %h, required %h", img, i, got_q[i], exp_q[i]);
          end
        end
      end
      vectors++;
      if ({err, err_code, full} !== {m_code != 0, m_code[1:0], exp_q.size() == DEPTH}) begin
        miscompares++;
        $display("FAIL rand_status[%0d]: got err=%b code=%0d full=%b, required err=%b code=%0d full=%b",
                 img, err, err_code, full, m_code != 0, m_code, exp_q.size() == DEPTH);
      end
    end
  endtask

`ifdef INST_ENC_NOP_PAD_EN
  task automatic test_pad();
    logic [AW+31:0] want;
    do_start();
    wr_ready = 1'b1;
    send(8, 1, 0, 0, 5);
    pad = 1'b1;
    tick();
    pad = 1'b0;
    for (int i = 0; i < 20 && !full; i++) tick();
    vectors++;
    if ({full, got_q.size() == DEPTH} !== 2'b11) begin
      miscompares++;
      $display("FAIL pad_full: got full=%b words=%0d, required full=1 words=%0d", full, got_q.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        want = (i == 0) ? {2'd0, 32'h00500093} : {i[AW-1:0], 32'h00000013};
        vectors++;
        if (got_q[i] !== want) begin
          miscompares++;
          $display("FAIL pad_word[%0d]: got %h, required %h", i, got_q[i], want);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_encode();
    test_errors();
    test_backpressure();
    test_full();
    test_random();
`ifdef INST_ENC_NOP_PAD_EN
    test_pad();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
